// File: rtl/cordic_rr_sched.sv
// Round-robin front end that shares one iterative CORDIC engine between
// several requesters. One job is in flight at a time. Each job is granted,
// started, run until the engine reports done or the timeout expires, and then
// returned tagged with the index of the requester that issued it.
module cordic_rr_sched #(
  parameter int gp_nr_req     = 4,
  parameter int gp_nr_iter    = 16,
  parameter int gp_xy_width   = 8,
  parameter int gp_z_width    = 8,
  parameter int gp_tmo_margin = 2
) (
  input  logic                                i_clk,
  input  logic                                i_rst_an,
  input  logic                                i_ena,
  input  logic [gp_nr_req-1:0]                i_req_valid,
  output logic [gp_nr_req-1:0]                o_req_ready,
  input  logic [gp_nr_req*gp_xy_width-1:0]    i_req_x,
  input  logic [gp_nr_req*gp_xy_width-1:0]    i_req_y,
  input  logic [gp_nr_req*gp_z_width-1:0]     i_req_z,
  output logic                                o_core_start,
  output logic                                o_core_ena,
  output logic [gp_xy_width-1:0]              o_core_x,
  output logic [gp_xy_width-1:0]              o_core_y,
  output logic [gp_z_width-1:0]               o_core_z,
  input  logic                                i_core_done,
  input  logic [gp_xy_width-1:0]              i_core_x,
  input  logic [gp_xy_width-1:0]              i_core_y,
  input  logic [gp_z_width-1:0]               i_core_z,
  output logic                                o_res_valid,
  input  logic                                i_res_ready,
  output logic [gp_xy_width-1:0]              o_res_x,
  output logic [gp_xy_width-1:0]              o_res_y,
  output logic [gp_z_width-1:0]               o_res_z,
  output logic [$clog2(gp_nr_req)-1:0]        o_res_id,
  output logic                                o_res_err,
  output logic                                o_busy
);

  localparam int lp_id_w   = $clog2(gp_nr_req);
  localparam int lp_cand_w = lp_id_w + 1;
  localparam int lp_tmo    = gp_nr_iter + gp_tmo_margin;
  localparam int lp_cnt_w  = $clog2(lp_tmo + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [lp_id_w-1:0]     last_r;
  logic [lp_id_w-1:0]     id_r;
  logic [lp_id_w-1:0]     grant_s;
  logic                   found_s;
  logic                   hit_s;
  logic [lp_cand_w-1:0]   sum_s;
  logic [lp_cand_w-1:0]   cand_s;
  logic [lp_cnt_w-1:0]    cnt_r;
  logic                   accept_s;
  logic                   done_s;
  logic                   tmo_s;
  logic                   res_hs_s;
  logic [gp_xy_width-1:0] op_x_r;
  logic [gp_xy_width-1:0] op_y_r;
  logic [gp_z_width-1:0]  op_z_r;
  logic [gp_xy_width-1:0] res_x_r;
  logic [gp_xy_width-1:0] res_y_r;
  logic [gp_z_width-1:0]  res_z_r;
  logic                   res_err_r;
  logic                   res_valid_r;

  // Round-robin search: first valid requester after the last one granted.
  always_comb begin
    grant_s = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    sum_s   = '0;
    cand_s  = '0;
    for (int i = 1; i <= gp_nr_req; i++) begin
      sum_s   = {1'b0, last_r} + lp_cand_w'(i);
      cand_s  = (sum_s >= lp_cand_w'(gp_nr_req)) ? (sum_s - lp_cand_w'(gp_nr_req)) : sum_s;
      hit_s   = !found_s && i_req_valid[cand_s[lp_id_w-1:0]];
      grant_s = hit_s ? cand_s[lp_id_w-1:0] : grant_s;
      found_s = found_s | hit_s;
    end
  end

  assign accept_s = i_ena && (state_r == ST_IDLE) && found_s;
  assign done_s   = i_ena && (state_r == ST_RUN) && i_core_done;
  assign tmo_s    = i_ena && (state_r == ST_RUN) && !i_core_done &&
                    (cnt_r == lp_cnt_w'(lp_tmo - 1));
  assign res_hs_s = i_ena && (state_r == ST_OUT) && i_res_ready;

  // One-hot accept toward the granted requester, only while a grant is taken.
  always_comb begin
    o_req_ready = '0;
    if (accept_s) begin
      o_req_ready[grant_s] = 1'b1;
    end else begin
      o_req_ready = '0;
    end
  end

  // Next-state logic; a disabled cycle leaves the state untouched.
  always_comb begin
    state_nxt_s = state_r;
    if (!i_ena) begin
      state_nxt_s = state_r;
    end else begin
      case (state_r)
        ST_IDLE:  state_nxt_s = found_s ? ST_START : ST_IDLE;
        ST_START: state_nxt_s = ST_RUN;
        ST_RUN:   state_nxt_s = (done_s || tmo_s) ? ST_OUT : ST_RUN;
        ST_OUT:   state_nxt_s = res_hs_s ? ST_IDLE : ST_OUT;
        default:  state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture, grant pointer, iteration counter and result registers.
  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      last_r      <= lp_id_w'(gp_nr_req - 1);
      id_r        <= '0;
      op_x_r      <= '0;
      op_y_r      <= '0;
      op_z_r      <= '0;
      cnt_r       <= '0;
      res_x_r     <= '0;
      res_y_r     <= '0;
      res_z_r     <= '0;
      res_err_r   <= 1'b0;
      res_valid_r <= 1'b0;
    end else begin
      if (accept_s) begin
        op_x_r <= i_req_x[grant_s*gp_xy_width +: gp_xy_width];
        op_y_r <= i_req_y[grant_s*gp_xy_width +: gp_xy_width];
        op_z_r <= i_req_z[grant_s*gp_z_width +: gp_z_width];
        id_r   <= grant_s;
        last_r <= grant_s;
      end
      if (i_ena && (state_r == ST_START)) begin
        cnt_r <= '0;
      end else if (i_ena && (state_r == ST_RUN)) begin
        cnt_r <= cnt_r + lp_cnt_w'(1);
      end
      // A done in the final allowed cycle still counts as a good result.
      if (done_s) begin
        res_x_r     <= i_core_x;
        res_y_r     <= i_core_y;
        res_z_r     <= i_core_z;
        res_err_r   <= 1'b0;
        res_valid_r <= 1'b1;
      end else if (tmo_s) begin
        res_x_r     <= '0;
        res_y_r     <= '0;
        res_z_r     <= '0;
        res_err_r   <= 1'b1;
        res_valid_r <= 1'b1;
      end else if (res_hs_s) begin
        res_valid_r <= 1'b0;
      end
    end
  end

  assign o_core_start = i_ena && (state_r == ST_START);
  assign o_core_ena   = i_ena && ((state_r == ST_START) || (state_r == ST_RUN));
  assign o_core_x     = op_x_r;
  assign o_core_y     = op_y_r;
  assign o_core_z     = op_z_r;
  assign o_res_valid  = res_valid_r;
  assign o_res_x      = res_x_r;
  assign o_res_y      = res_y_r;
  assign o_res_z      = res_z_r;
  assign o_res_id     = id_r;
  assign o_res_err    = res_err_r;
  assign o_busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_cordic_rr_sched.sv
// Bench for cordic_rr_sched: directed job table, reset/freeze corner cases and
// a randomized run against a transaction-level round-robin model.
module tb_cordic_rr_sched;

  logic        clk = 1'b0;
  logic        rst_an;
  logic        ena;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_x, req_y, req_z;
  logic        core_start, core_ena, core_done;
  logic [7:0]  core_x, core_y, core_z;
  logic [7:0]  eng_rx, eng_ry, eng_rz;
  logic        res_valid, res_ready, res_err, busy;
  logic [7:0]  res_x, res_y, res_z;
  logic [1:0]  res_id;

  int          n_chk  = 0;
  int          n_fail = 0;

  // Engine model state
  int          eng_delay;
  int          eng_cnt;
  logic        eng_done;
  logic        done_force;

  assign core_done = eng_done | done_force;

  cordic_rr_sched dut (
    .i_clk(clk), .i_rst_an(rst_an), .i_ena(ena),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_x(req_x), .i_req_y(req_y), .i_req_z(req_z),
    .o_core_start(core_start), .o_core_ena(core_ena),
    .o_core_x(core_x), .o_core_y(core_y), .o_core_z(core_z),
    .i_core_done(core_done), .i_core_x(eng_rx), .i_core_y(eng_ry), .i_core_z(eng_rz),
    .o_res_valid(res_valid), .i_res_ready(res_ready),
    .o_res_x(res_x), .o_res_y(res_y), .o_res_z(res_z),
    .o_res_id(res_id), .o_res_err(res_err), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // Engine: counts its enabled run cycles after a start pulse and raises done
  // in run cycle eng_delay (0 means it never finishes).
  initial begin
    eng_done = 1'b0;
    eng_cnt  = 0;
    forever begin
      @(negedge clk);
      if (core_start) begin
        eng_cnt  = 0;
        eng_done = 1'b0;
      end else if (core_ena) begin
        eng_cnt++;
        eng_done = (eng_delay != 0) && (eng_cnt == eng_delay);
      end else begin
        eng_done = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1 ms");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] v;
    logic [7:0] x, y, z;
    int         dly;
    logic [7:0] rx, ry, rz;
    int         hold;
    int         gap;
    int         eg;
    logic       ee;
    logic [7:0] ex, ey, ez;
  } vec_t;

  vec_t tbl [12];
  vec_t rv;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] onehot(input int g);
    logic [3:0] r;
    r = 4'b0000;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  // Reference arbitration: scan forward from the last grant, wrapping around.
  function automatic int rr_pick(input logic [3:0] v, input int last);
    for (int i = 1; i <= 4; i++) begin
      int k;
      k = (last + i) % 4;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [23:0] eng_f(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    return {x + y, y - x, z ^ 8'hA5};
  endfunction

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_ctl"}, {req_ready, core_start, core_ena, res_valid, res_err, busy, res_id}, 64'd0);
    chk({nm, "_data"}, {core_x, core_y, core_z, res_x, res_y, res_z}, 64'd0);
  endtask

  // Runs one complete job: grant, start, engine run, result, optional hold in
  // the result state and optional i_ena freeze while running.
  task automatic run_job(input vec_t t);
    int   n, cyc, exp_lat;
    logic gapped;
    eng_delay = t.dly;
    eng_rx = t.rx; eng_ry = t.ry; eng_rz = t.rz;
    res_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req_x[k*8 +: 8] = (k == t.eg) ? t.x : ~t.x;
      req_y[k*8 +: 8] = (k == t.eg) ? t.y : ~t.y;
      req_z[k*8 +: 8] = (k == t.eg) ? t.z : ~t.z;
    end
    req_valid = t.v;
    #1;
    n = 0;
    while (req_ready == 4'b0000 && n < 50) begin
      step(); #1; n++;
    end
    chk("grant", req_ready, onehot(t.eg));
    step();
    req_valid[t.eg] = 1'b0;
    #1;
    chk("start_pulse", {core_start, core_ena, busy}, 3'b111);
    chk("core_ops", {core_x, core_y, core_z}, {t.x, t.y, t.z});
    exp_lat = ((t.dly >= 1 && t.dly <= 18) ? t.dly + 2 : 20) + t.gap;
    cyc = 1;
    gapped = 1'b0;
    while (!res_valid && cyc < 80) begin
      if (cyc == 4 && t.gap > 0 && !gapped) begin
        gapped = 1'b1;
        ena = 1'b0;
        #1;
        chk("frozen", {core_ena, core_start, res_valid, busy}, 4'b0001);
        repeat (t.gap - 1) begin
          step(); #1;
          chk("frozen", {core_ena, core_start, res_valid, busy}, 4'b0001);
        end
        step();
        ena = 1'b1;
        #1;
        cyc += t.gap;
      end else begin
        step(); #1; cyc++;
        if (!res_valid) chk("run_quiet", {core_start, req_ready, core_ena}, 6'b000001);
      end
    end
    chk("latency", cyc, exp_lat);
    chk("result", {res_x, res_y, res_z, res_id, res_err}, {t.ex, t.ey, t.ez, 2'(t.eg), t.ee});
    for (int h = 0; h < t.hold; h++) begin
      done_force = 1'b1;
      eng_rx = eng_rx + 8'd1;
      step(); #1;
      chk("hold_stable", {res_valid, res_x, res_y, res_z, res_id, res_err, req_ready},
          {1'b1, t.ex, t.ey, t.ez, 2'(t.eg), t.ee, 4'b0000});
    end
    done_force = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    req_valid = 4'b0000;
    #1;
    chk("released", {res_valid, busy}, 2'b00);
  endtask

  // Randomized phase state
  logic [3:0] pend;
  logic [7:0] px [4];
  logic [7:0] py [4];
  logic [7:0] pz [4];
  int         m_last;
  logic       m_idle;
  int         g;
  int         jdly;
  logic [26:0] exp_res;

  initial begin
    ena = 1'b1; req_valid = 4'b0; req_x = '0; req_y = '0; req_z = '0;
    res_ready = 1'b0; done_force = 1'b0; eng_delay = 0;
    eng_rx = 8'd0; eng_ry = 8'd0; eng_rz = 8'd0;
    rst_an = 1'b1;
    #2 rst_an = 1'b0;
    step(); step(); #1;
    check_reset_outputs("reset");
    step();
    rst_an = 1'b1;

    //          v        x      y      z      dly  rx     ry     rz     hold gap eg ee  ex     ey     ez
    tbl[0]  = '{4'b1111, 8'd1,  8'd2,  8'd3,  5,  8'd11, 8'd12, 8'd13, 0, 0, 0, 1'b0, 8'd11, 8'd12, 8'd13};
    tbl[1]  = '{4'b1111, 8'd4,  8'd5,  8'd6,  6,  8'd21, 8'd22, 8'd23, 0, 0, 1, 1'b0, 8'd21, 8'd22, 8'd23};
    tbl[2]  = '{4'b1111, 8'd7,  8'd8,  8'd9,  7,  8'd31, 8'd32, 8'd33, 0, 0, 2, 1'b0, 8'd31, 8'd32, 8'd33};
    tbl[3]  = '{4'b1111, 8'd10, 8'd11, 8'd12, 8,  8'd41, 8'd42, 8'd43, 0, 0, 3, 1'b0, 8'd41, 8'd42, 8'd43};
    tbl[4]  = '{4'b1111, 8'd13, 8'd14, 8'd15, 9,  8'd51, 8'd52, 8'd53, 0, 0, 0, 1'b0, 8'd51, 8'd52, 8'd53};
    tbl[5]  = '{4'b0100, 8'd40, 8'd0,  8'd32, 16, 8'd24, 8'd30, 8'd0,  10, 0, 2, 1'b0, 8'd24, 8'd30, 8'd0};
    tbl[6]  = '{4'b1010, 8'h61, 8'h62, 8'h63, 3,  8'h10, 8'h20, 8'h30, 0, 0, 3, 1'b0, 8'h10, 8'h20, 8'h30};
    tbl[7]  = '{4'b1010, 8'h71, 8'h72, 8'h73, 4,  8'hF0, 8'hE0, 8'hD0, 0, 0, 1, 1'b0, 8'hF0, 8'hE0, 8'hD0};
    tbl[8]  = '{4'b0001, 8'h81, 8'h82, 8'h83, 18, 8'h7F, 8'h80, 8'h55, 0, 0, 0, 1'b0, 8'h7F, 8'h80, 8'h55};
    tbl[9]  = '{4'b0001, 8'h91, 8'h92, 8'h93, 19, 8'd1,  8'd2,  8'd3,  0, 0, 0, 1'b1, 8'd0,  8'd0,  8'd0};
    tbl[10] = '{4'b0010, 8'hA1, 8'hA2, 8'hA3, 0,  8'd9,  8'd9,  8'd9,  0, 5, 1, 1'b1, 8'd0,  8'd0,  8'd0};
    tbl[11] = '{4'b1000, 8'hB1, 8'hB2, 8'hB3, 1,  8'hC8, 8'h38, 8'h9C, 0, 0, 3, 1'b0, 8'hC8, 8'h38, 8'h9C};

    for (int i = 0; i < 12; i++) run_job(tbl[i]);

    // A done pulse while idle must not produce a result.
    done_force = 1'b1;
    step(); done_force = 1'b0; #1;
    chk("idle_done_ignored", {res_valid, busy}, 2'b00);

    // Asynchronous reset in the middle of a run aborts the job.
    eng_delay = 0;
    req_x = {4{8'h5C}}; req_y = {4{8'h6D}}; req_z = {4{8'h7E}};
    req_valid = 4'b0100;
    #1;
    chk("pre_reset_grant", req_ready, 4'b0100);
    step();
    req_valid = 4'b0000;
    repeat (5) step();
    #1;
    chk("pre_reset_run", {busy, core_ena}, 2'b11);
    rst_an = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    step(); #1;
    check_reset_outputs("held_reset");
    step();
    rst_an = 1'b1;
    rv = '{4'b1111, 8'h12, 8'h34, 8'h56, 2, 8'h65, 8'h43, 8'h21, 0, 0, 0, 1'b0, 8'h65, 8'h43, 8'h21};
    run_job(rv);

    // Randomized traffic against the transaction-level model.
    pend = 4'b0000;
    m_last = 0;
    m_idle = 1'b1;
    exp_res = '0;
    for (int k = 0; k < 4; k++) begin px[k] = 8'd0; py[k] = 8'd0; pz[k] = 8'd0; end
    for (int c = 0; c < 2500; c++) begin
      step();
      for (int k = 0; k < 4; k++) begin
        if (!pend[k] && $urandom_range(3) == 0) begin
          pend[k] = 1'b1;
          px[k] = 8'($urandom); py[k] = 8'($urandom); pz[k] = 8'($urandom);
        end
        req_x[k*8 +: 8] = px[k];
        req_y[k*8 +: 8] = py[k];
        req_z[k*8 +: 8] = pz[k];
      end
      req_valid = pend;
      ena = ($urandom_range(7) != 0);
      res_ready = 1'($urandom_range(1));
      #1;
      g = (m_idle && ena) ? rr_pick(pend, m_last) : -1;
      chk("rand_ready", req_ready, onehot(g));
      chk("rand_busy", busy, !m_idle);
      if (!m_idle && res_valid) begin
        chk("rand_result", {res_x, res_y, res_z, res_id, res_err}, exp_res);
        if (res_ready && ena) m_idle = 1'b1;
      end
      if (g >= 0) begin
        m_idle = 1'b0;
        m_last = g;
        pend[g] = 1'b0;
        jdly = $urandom_range(20);
        eng_delay = jdly;
        {eng_rx, eng_ry, eng_rz} = eng_f(px[g], py[g], pz[g]);
        if (jdly >= 1 && jdly <= 18) exp_res = {eng_f(px[g], py[g], pz[g]), 2'(g), 1'b0};
        else                         exp_res = {24'd0, 2'(g), 1'b1};
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
